// File: rtl/lut_or_stream_i8.sv
// Streaming 8-bit OR responder: operand pairs in, a|b out through a small result FIFO.
// Optional completed-result counter enabled by defining LUT_OR_STATS_EN.
module lut_or_stream_i8 #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [15:0]      count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH + 1);
   localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             push_s;
   logic             pop_s;

   assign push_s = in_valid & in_ready_q;
   assign pop_s  = out_valid_q & out_ready;

   // Next FIFO state; y and the handshake flags are decoded from it so they can be registered.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = a | b;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
      if (occ_d != OW'(0)) begin
         y_d = mem_d[rd_ptr_d];
      end else begin
         y_d = y_q;
      end
      in_ready_d  = (occ_d != OCC_FULL);
      out_valid_d = (occ_d != OW'(0));
   end

   // FIFO storage, pointers and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         y_q         <= '0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y         = y_q;

`ifdef LUT_OR_STATS_EN
   logic [15:0] count_q, count_d;

   // Saturating count of delivered results.
   always_comb begin
      if (pop_s && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register, cleared only by reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= 16'h0000;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
`else
   assign count = 16'h0000;
`endif

endmodule

// File: tb/tb_lut_or_stream_i8.sv
// Directed bench for lut_or_stream_i8; expected count follows LUT_OR_STATS_EN.
module tb_lut_or_stream_i8;

`ifdef LUT_OR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
   logic [15:0] count;

   int total = 0;
   int bad   = 0;
   int pops  = 0;

   lut_or_stream_i8 dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .count     (count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] exp_count();
      if (!STATS) return 16'h0000;
      if (pops > 65535) return 16'hFFFF;
      return 16'(pops);
   endfunction

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0;
      repeat (16) step();
      pops = 0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0d exp=1", in_ready); end
      total++; if (y !== 8'd0) begin bad++; $display("FAIL rst_y got=%0d exp=0", y); end
      total++; if (count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
      reset = 1'b1;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_rel_valid got=%0d exp=0", out_valid); end
   endtask

   task automatic test_single();
      out_ready = 1'b1; in_valid = 1'b1; a = 8'd3; b = 8'd8;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0d exp=1", out_valid); end
      total++; if (y !== 8'd11) begin bad++; $display("FAIL single_y got=%0d exp=11", y); end
      step();
      pops++;
      total++; if (count !== exp_count()) begin bad++; $display("FAIL single_count got=%0d exp=%0d", count, exp_count()); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0d exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; a = 8'd3; b = 8'd8;
      step();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%0d exp=1", in_ready); end
      a = 8'd16; b = 8'd1;
      step();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0d exp=0", in_ready); end
      a = 8'd240; b = 8'd15;
      step();
      total++; if (y !== 8'd11) begin bad++; $display("FAIL bp_hold_y got=%0d exp=11", y); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%0d exp=1", out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_still_full got=%0d exp=0", in_ready); end
      out_ready = 1'b1;
      step();
      pops++;
      total++; if (y !== 8'd17) begin bad++; $display("FAIL bp_y2 got=%0d exp=17", y); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready2 got=%0d exp=1", in_ready); end
      step();
      pops++;
      in_valid = 1'b0;
      total++; if (y !== 8'd255) begin bad++; $display("FAIL bp_y3 got=%0d exp=255", y); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid3 got=%0d exp=1", out_valid); end
      step();
      pops++;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0d exp=0", out_valid); end
      total++; if (count !== exp_count()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", count, exp_count()); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; a = 8'(i); b = 8'h80;
         step();
         if (i > 0) pops++;
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%0d exp=1", i, in_ready); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0d exp=1", i, out_valid); end
         total++; if (y !== (8'h80 | 8'(i))) begin bad++; $display("FAIL stream_y[%0d] got=%0h exp=%0h", i, y, 8'h80 | 8'(i)); end
      end
      in_valid = 1'b0;
      step();
      pops++;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0d exp=0", out_valid); end
      total++; if (count !== exp_count()) begin bad++; $display("FAIL stream_count got=%0d exp=%0d", count, exp_count()); end
   endtask

   task automatic test_simul();
      out_ready = 1'b0; in_valid = 1'b1; a = 8'd5; b = 8'd0;
      step();
      out_ready = 1'b1; a = 8'd1; b = 8'd2;
      step();
      pops++;
      total++; if (y !== 8'd3) begin bad++; $display("FAIL simul_y got=%0d exp=3", y); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL simul_valid got=%0d exp=1", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL simul_ready got=%0d exp=1", in_ready); end
      out_ready = 1'b0; a = 8'd7; b = 8'd0;
      step();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL simul_occ got=%0d exp=0", in_ready); end
      total++; if (y !== 8'd3) begin bad++; $display("FAIL simul_hold got=%0d exp=3", y); end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      pops++;
      total++; if (y !== 8'd7) begin bad++; $display("FAIL simul_wrap got=%0d exp=7", y); end
      step();
      pops++;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL simul_drain got=%0d exp=0", out_valid); end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0; in_valid = 1'b1; a = 8'd3; b = 8'd8;
      step();
      a = 8'd4;
      step();
      in_valid = 1'b0; reset = 1'b0;
      step();
      pops = 0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%0d exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%0d exp=1", in_ready); end
      total++; if (count !== 16'd0) begin bad++; $display("FAIL mrst_count got=%0d exp=0", count); end
      total++; if (y !== 8'd0) begin bad++; $display("FAIL mrst_y got=%0d exp=0", y); end
      reset = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_stale[%0d] got=%0d y=%0d exp=0", i, out_valid, y); end
      end
   endtask

   task automatic test_saturation();
      int n;
      n = STATS ? 65540 : 200;
      out_ready = 1'b1; in_valid = 1'b1; b = 8'd0;
      for (int i = 0; i < n; i++) begin
         a = 8'(i);
         step();
         if (i > 0) pops++;
         if (i == 100) begin
            total++; if (count !== exp_count()) begin bad++; $display("FAIL sat_mid got=%0d exp=%0d", count, exp_count()); end
            total++; if (y !== 8'd100) begin bad++; $display("FAIL sat_y got=%0d exp=100", y); end
         end
      end
      in_valid = 1'b0;
      step();
      pops++;
      total++; if (count !== exp_count()) begin bad++; $display("FAIL sat_count got=%0h exp=%0h", count, exp_count()); end
      repeat (3) step();
      total++; if (count !== exp_count()) begin bad++; $display("FAIL sat_hold got=%0h exp=%0h", count, exp_count()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_simul();
      test_mid_reset();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
